// File: rtl/axi_stream_pkg.sv
// Shared AXI4-Stream video constants and types used by the stream sources and sinks.
package axi_stream_pkg;

    localparam int PIXEL_WIDTH_8  = 8;
    localparam int IMG_WIDTH_MAX  = 1920;
    localparam int IMG_HEIGHT_MAX = 1080;

    typedef enum logic [1:0] {
        HRAMP   = 2'd0,
        VRAMP   = 2'd1,
        CHECKER = 2'd2,
        FRAMEID = 2'd3
    } tpg_pattern_t;

endpackage

// File: rtl/tpg_pixel_fn.sv
// Combinational pixel generator: maps a pixel position, frame number and pattern to a value.
module tpg_pixel_fn
    import axi_stream_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_WIDTH_8,
    parameter int XW         = 11,
    parameter int YW         = 11
) (
    input  logic [XW-1:0]         x,
    input  logic [YW-1:0]         y,
    input  logic [15:0]           frame_cnt,
    input  tpg_pattern_t          pattern,
    output logic [DATA_WIDTH-1:0] pixel
);

    always_comb begin
        // NOTE: default first so every path assigns pixel and no latch is inferred.
        pixel = '0;
        unique case (pattern)
            HRAMP:   pixel = DATA_WIDTH'(x);
            VRAMP:   pixel = DATA_WIDTH'(y);
            CHECKER: pixel = {DATA_WIDTH{x[3] ^ y[3]}};
            FRAMEID: pixel = DATA_WIDTH'(frame_cnt);
        endcase
    end

endmodule

// File: rtl/axis_test_pattern_gen.sv
// AXI4-Stream test pattern source: frames of W x H pixels with TUSER on the first pixel and TLAST per line.
module axis_test_pattern_gen #(
    parameter int DATA_WIDTH     = axi_stream_pkg::PIXEL_WIDTH_8,
    parameter int IMG_WIDTH_MAX  = axi_stream_pkg::IMG_WIDTH_MAX,
    parameter int IMG_HEIGHT_MAX = axi_stream_pkg::IMG_HEIGHT_MAX,
    localparam int CW            = $clog2(IMG_WIDTH_MAX + 1),
    localparam int CH            = $clog2(IMG_HEIGHT_MAX + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CW-1:0]                cfg_width,
    input  logic [CH-1:0]                cfg_height,
    input  axi_stream_pkg::tpg_pattern_t cfg_pattern,
    output logic [DATA_WIDTH-1:0]        m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    output logic                         busy,
    output logic                         cfg_err,
    output logic [15:0]                  frame_cnt
);

    import axi_stream_pkg::*;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tpg_state_t;

    tpg_state_t      state_q, state_d;
    logic            pend_q, pend_d;
    logic [CW-1:0]   x_q, x_d, w_q, w_d;
    logic [CH-1:0]   y_q, y_d, h_q, h_d;
    tpg_pattern_t    pat_q, pat_d;
    logic [15:0]     fc_d;
    logic            valid_d, err_d, hs, start_ok;
    logic [DATA_WIDTH-1:0] pix_d;

    function automatic logic cfg_ok(input logic [CW-1:0] w, input logic [CH-1:0] h);
        return (w != '0) && (w <= CW'(IMG_WIDTH_MAX)) &&
               (h != '0) && (h <= CH'(IMG_HEIGHT_MAX));
    endfunction

    assign hs       = m_axis_tvalid & m_axis_tready;
    assign start_ok = pend_q && cfg_ok(w_q, h_q);
    assign busy     = (state_q == ST_RUN);

    // IDLE captures the config one cycle ahead of checking it; the end-of-frame
    // resample in RUN checks the live inputs so back-to-back frames have no bubble.
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        pat_d   = pat_q;
        fc_d    = frame_cnt;
        valid_d = m_axis_tvalid;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (start_ok) begin
                    state_d = ST_RUN;
                    x_d     = '0;
                    y_d     = '0;
                    valid_d = 1'b1;
                end else begin
                    err_d = pend_q;
                    if (enable) begin
                        w_d    = cfg_width;
                        h_d    = cfg_height;
                        pat_d  = cfg_pattern;
                        pend_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (hs) begin
                    if (x_q == w_q - CW'(1)) begin
                        x_d = '0;
                        if (y_q == h_q - CH'(1)) begin
                            y_d  = '0;
                            fc_d = frame_cnt + 16'd1;
                            if (enable && cfg_ok(cfg_width, cfg_height)) begin
                                w_d   = cfg_width;
                                h_d   = cfg_height;
                                pat_d = cfg_pattern;
                            end else begin
                                state_d = ST_IDLE;
                                valid_d = 1'b0;
                                err_d   = enable;
                            end
                        end else begin
                            y_d = y_q + CH'(1);
                        end
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
            end
        endcase
    end

    tpg_pixel_fn #(
        .DATA_WIDTH (DATA_WIDTH),
        .XW         (CW),
        .YW         (CH)
    ) u_pixel_fn (
        .x         (x_d),
        .y         (y_d),
        .frame_cnt (fc_d),
        .pattern   (pat_d),
        .pixel     (pix_d)
    );

    // Outputs are registered from the next-state position, so they hold while stalled.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q       <= ST_IDLE;
            pend_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            w_q           <= '0;
            h_q           <= '0;
            pat_q         <= HRAMP;
            frame_cnt     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            x_q           <= x_d;
            y_q           <= y_d;
            w_q           <= w_d;
            h_q           <= h_d;
            pat_q         <= pat_d;
            frame_cnt     <= fc_d;
            m_axis_tvalid <= valid_d;
            m_axis_tdata  <= valid_d ? pix_d : '0;
            m_axis_tlast  <= valid_d && (x_d == w_d - CW'(1));
            m_axis_tuser  <= valid_d && (x_d == '0) && (y_d == '0);
            cfg_err       <= err_d;
        end
    end

endmodule

// File: tb/tb_axis_test_pattern_gen.sv
// Directed self-checking bench for axis_test_pattern_gen with hand-computed expectations.
module tb_axis_test_pattern_gen;
    import axi_stream_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [10:0]  cfg_width;
    logic [10:0]  cfg_height;
    tpg_pattern_t cfg_pattern;
    logic [7:0]   tdata;
    logic         tvalid, tready, tlast, tuser, busy, cfg_err;
    logic [15:0]  frame_cnt;

    int total  = 0;
    int passed = 0;

    axis_test_pattern_gen dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .cfg_pattern   (cfg_pattern),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .m_axis_tuser  (tuser),
        .busy          (busy),
        .cfg_err       (cfg_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    logic [7:0] pix [16][16];
    int mx, my, beats, cyc, errs, vals;
    logic hs;

    initial begin
        rst = 1'b1; enable = 1'b0; tready = 1'b1;
        cfg_width = '0; cfg_height = '0; cfg_pattern = HRAMP;
        tick(); tick();
        check("reset_flags", {tvalid, tlast, tuser, busy, cfg_err}, 5'b0);
        check("reset_tdata", tdata, 8'h00);
        check("reset_frame_cnt", frame_cnt, 16'h0);
        rst = 1'b0;

        // W=4 H=2 HRAMP, single-cycle enable pulse
        cfg_width = 11'd4; cfg_height = 11'd2; cfg_pattern = HRAMP; enable = 1'b1;
        tick();
        enable = 1'b0;
        check("t1_latency_idle", tvalid, 1'b0);
        tick();
        check("t1_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_flags_%0d", i), {tvalid, tuser, tlast},
                  {1'b1, i == 0, (i % 4) == 3});
            check($sformatf("t1_tdata_%0d", i), tdata, 32'(i % 4));
            tick();
        end
        check("t1_idle_flags", {tvalid, busy}, 2'b00);
        check("t1_frame_cnt", frame_cnt, 16'd1);

        // W=16 H=16 CHECKER with random stalls
        cfg_width = 11'd16; cfg_height = 11'd16; cfg_pattern = CHECKER; enable = 1'b1;
        tready = 1'b0;
        tick();
        enable = 1'b0;
        tick();
        mx = 0; my = 0; beats = 0; cyc = 0;
        while (beats < 256 && cyc < 2000) begin
            check("t2_flags", {tvalid, tuser, tlast}, {1'b1, mx == 0 && my == 0, mx == 15});
            check("t2_tdata", tdata, ((((mx >> 3) ^ (my >> 3)) & 1) != 0) ? 32'hFF : 32'h00);
            tready = 1'($urandom_range(0, 1));
            hs = tready;
            if (hs) begin
                pix[my][mx] = tdata;
                beats++;
                if (mx == 15) begin
                    mx = 0;
                    my++;
                end else begin
                    mx++;
                end
            end
            tick();
            cyc++;
        end
        check("t2_beats", beats, 256);
        check("t2_pix_8_0", pix[0][8], 8'hFF);
        check("t2_pix_8_8", pix[8][8], 8'h00);
        check("t2_pix_0_0", pix[0][0], 8'h00);
        check("t2_idle", tvalid, 1'b0);
        check("t2_frame_cnt", frame_cnt, 16'd2);

        // W=3 H=1 FRAMEID back-to-back after a fresh reset
        rst = 1'b1; tready = 1'b1;
        tick();
        rst = 1'b0;
        cfg_width = 11'd3; cfg_height = 11'd1; cfg_pattern = FRAMEID; enable = 1'b1;
        tick(); tick();
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t3_flags_%0d", i), {tvalid, tuser, tlast},
                  {1'b1, (i % 3) == 0, (i % 3) == 2});
            check($sformatf("t3_tdata_%0d", i), tdata, 32'(i / 3));
            tick();
        end
        enable = 1'b0;
        check("t3_fourth_frame", tdata, 8'd3);
        tick(); tick(); tick();
        check("t3_idle", tvalid, 1'b0);
        check("t3_frame_cnt", frame_cnt, 16'd4);

        // Bad config: zero width, then oversize height
        for (int k = 0; k < 2; k++) begin
            cfg_width  = (k == 0) ? 11'd0 : 11'd4;
            cfg_height = (k == 0) ? 11'd2 : 11'd1081;
            enable = 1'b1; errs = 0; vals = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (i == 2) enable = 1'b0;
                errs += int'(cfg_err);
                vals += int'(tvalid);
            end
            check($sformatf("t4_err_cycles_%0d", k), errs, 3);
            check($sformatf("t4_no_valid_%0d", k), vals, 0);
        end

        // Reset mid-frame on W=8 H=4
        cfg_width = 11'd8; cfg_height = 11'd4; cfg_pattern = HRAMP; enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        repeat (5) tick();
        check("t5_beat5", tdata, 8'd5);
        rst = 1'b1;
        tick();
        check("t5_rst_flags", {tvalid, tlast, tuser, busy}, 4'b0);
        check("t5_rst_frame_cnt", frame_cnt, 16'd0);
        rst = 1'b0; enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        check("t5_restart_flags", {tvalid, tuser}, 2'b11);
        check("t5_restart_tdata", tdata, 8'd0);
        check("t5_restart_frame_cnt", frame_cnt, 16'd0);
        repeat (32) tick();
        check("t5_done", {tvalid, frame_cnt}, {1'b0, 16'd1});

        // W=1 H=1 continuous with frame counter wrap
        force dut.frame_cnt = 16'hFFFE;
        tick();
        release dut.frame_cnt;
        cfg_width = 11'd1; cfg_height = 11'd1; cfg_pattern = FRAMEID; enable = 1'b1;
        tick(); tick();
        check("t6_beat0", {tvalid, tuser, tlast, tdata}, {3'b111, 8'hFE});
        check("t6_cnt0", frame_cnt, 16'hFFFE);
        tick();
        check("t6_beat1", {tvalid, tuser, tlast, tdata}, {3'b111, 8'hFF});
        check("t6_cnt1", frame_cnt, 16'hFFFF);
        tick();
        check("t6_beat2", {tvalid, tuser, tlast, tdata}, {3'b111, 8'h00});
        check("t6_wrap", frame_cnt, 16'h0000);
        tick();
        check("t6_cnt3", frame_cnt, 16'h0001);
        enable = 1'b0;
        tick();
        check("t6_idle", {tvalid, frame_cnt}, {1'b0, 16'h0002});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axis_test_pattern_gen.md
# axis_test_pattern_gen

AXI4-Stream video transmitter producing synthetic frames (ramps, checkerboard, frame-ID fill) framed with TUSER start-of-frame and TLAST end-of-line markers. It sits at the head of the processing chain and drives filter and sink blocks with known, deterministic content during bring-up and regression.

## Interface
Parameters:
- DATA_WIDTH, 8 (PIXEL_WIDTH_8): pixel/TDATA width in bits; must be ≥ 4.
- IMG_WIDTH_MAX, 1920: largest accepted line length in pixels.
- IMG_HEIGHT_MAX, 1080: largest accepted frame height in lines.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; while high, frames are generated back-to-back.
- cfg_width  in  CW  active pixels per line; CW = $clog2(IMG_WIDTH_MAX+1).
- cfg_height  in  CH  lines per frame; CH = $clog2(IMG_HEIGHT_MAX+1).
- cfg_pattern  in  2  pattern select, tpg_pattern_t.
- m_axis_tdata  out  DATA_WIDTH  pixel value.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame.
- busy  out  1  high while in RUN.
- cfg_err  out  1  one-cycle pulse: frame start refused due to bad config.
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0.

## Operation
- States: IDLE, RUN.
- IDLE: tvalid=0. If enable=1, sample cfg_* into shadow registers. If width or height is 0, or exceeds its MAX, stay IDLE and pulse cfg_err; else go to RUN with x=0, y=0.
- RUN: present pixel (x,y). On handshake (tvalid & tready): if x = W-1, set x=0 and increment y; else increment x.
- Last pixel (x=W-1, y=H-1) accepted: increment frame_cnt. If enable=1, resample config (same validity check) and start next frame the following cycle; else return to IDLE. Invalid resample → IDLE plus cfg_err.
- enable falling mid-frame: current frame completes; no truncation.
- cfg_* changes mid-frame are ignored until next sample.
- tuser = (x==0 && y==0); tlast = (x==W-1). W=1 gives tlast on every pixel; W=1,H=1 gives tuser and tlast on the same beat.
- Patterns (d = DATA_WIDTH):
  - 0 HRAMP: x[d-1:0].
  - 1 VRAMP: y[d-1:0].
  - 2 CHECKER: all-ones if x[3]^y[3], else 0 (8×8 squares).
  - 3 FRAMEID: frame_cnt[d-1:0], constant over the frame.
- Counters wrap only via the explicit W/H compare, never by overflow.

## Timing
- Reset: tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, cfg_err=0, frame_cnt=0, state IDLE.
- Reset asserted mid-frame: outputs take reset values at the next edge. The partial frame is abandoned, with no TLAST.
- Start latency: enable sampled high in IDLE at edge N gives tvalid=1 and tuser=1 after edge N+1. busy rises at the same edge.
- Outputs are registered. Once tvalid=1, it stays high and tdata/tlast/tuser hold stable until the handshake.
- Throughput: 1 pixel/clk while tready=1. No bubble between lines or between back-to-back frames.
- tready never gates tvalid.
- cfg_err is high for exactly one cycle per refused start. Continuous bad config with enable=1 pulses it every cycle.

## Structure
- Add `tpg_pattern_t` (enum logic [1:0] {HRAMP, VRAMP, CHECKER, FRAMEID}) to axi_stream_pkg.
- Reuse the package constants IMG_WIDTH_MAX, IMG_HEIGHT_MAX and PIXEL_WIDTH_8.
- One sub-module: `tpg_pixel_fn`, combinational (x, y, frame_cnt, pattern) → pixel. The top level holds the FSM, counters and output register.

## Test plan
- W=4, H=2, HRAMP, tready=1, enable pulsed one cycle → 8 beats: tdata 0,1,2,3,0,1,2,3; tuser on beat 0 only; tlast on beats 3 and 7; frame_cnt=1; back in IDLE.
- W=16, H=16, CHECKER, random tready stalls (~50%) → tdata/tlast/tuser stable across every stall. Pixel (8,0)=0xFF, (8,8)=0x00, (0,0)=0x00.
- enable held high, W=3, H=1, FRAMEID → consecutive frames with no idle cycle; tdata 0,0,0,1,1,1,2,2,2; tuser every 3rd beat.
- cfg_width=0, enable=1 for 3 cycles → cfg_err high 3 cycles, tvalid stays 0. Same result for cfg_height=1081.
- rst asserted at beat 5 of a W=8, H=4 frame → tvalid=0 next cycle. After release with enable=1, the next frame starts at (0,0) with tuser=1 and frame_cnt=0.
- W=1, H=1, enable held → every beat has tuser=1 and tlast=1; frame_cnt increments each cycle; wrap from 0xFFFF to 0 checked via forced start value.
